// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO with a drain FSM feeding a uart send/txbusy handshake.
// Producers push at clk rate; bytes leave one per uart frame and never bypass the FIFO.
module uart_tx_queue #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    din,
    input  logic          push,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          clr_ovf,
    output logic [7:0]    tx_data,
    output logic          tx_send,
    input  logic          tx_busy
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_load;
    logic            w_pop;
    logic            w_push_ok;
    logic [CW-1:0]   w_count_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;
    logic [7:0]      r_tx_data;
    logic            r_tx_send;

    // A push is judged against full as registered at the start of the cycle.
    assign w_push_ok   = push && !r_full;
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop);

    // Drain FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain FSM next state; load on IDLE->LOAD, pop on LOAD->WAIT_DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_empty && !tx_busy) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Storage array; stale contents are harmless since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Sticky overflow; a dropped push beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (push && r_full) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // uart side: data latched at load and held; send high exactly while in LOAD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tx_data <= '0;
            r_tx_send <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
            r_tx_send <= (w_state_nxt == S_LOAD);
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;
    assign tx_send  = r_tx_send;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: behavioural uart responder plus expected-byte scoreboard.
module tb_uart_tx_queue;

    localparam int unsigned AW    = 4;
    localparam int          FRAME = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    din;
    logic          push;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          clr_ovf;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          tx_busy;

    logic          foreign_busy;
    logic          uart_en;
    logic          uart_busy = 1'b0;
    int            busy_cnt  = 0;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [7:0]    sb_q [$];

    uart_tx_queue #(.AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .push     (push),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = foreign_busy | uart_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Behavioural uart: takes a byte when send is seen while idle, then stays busy for a frame.
    always @(posedge clk) begin
        if (uart_busy) begin
            if (busy_cnt == 1) uart_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (uart_en && tx_send) begin
            uart_busy <= 1'b1;
            busy_cnt  <= FRAME;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rx_unexpected: got 0x%0h expected no byte", tx_data);
            end else begin
                check("rx_byte", 32'(tx_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        din  = b;
        push = 1'b1;
        @(negedge clk);
        push = 1'b0;
        if (accepted) sb_q.push_back(b);
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (sb_q.size() == 0 && empty && !tx_busy && !tx_send) done = 1'b1;
            else @(negedge clk);
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    initial begin
        reset        = 1'b0;
        din          = '0;
        push         = 1'b0;
        clr_ovf      = 1'b0;
        foreign_busy = 1'b0;
        uart_en      = 1'b1;

        // Reset held for four edges
        repeat (4) @(negedge clk);
        check("rst_count",    32'(count),    32'd0);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_tx_send",  32'(tx_send),  32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte: write edge, then IDLE sees !empty and raises send
        push_byte(8'hA9, 1'b1);
        check("lat_send_after_write", 32'(tx_send), 32'd0);
        check("lat_count_after_write", 32'(count), 32'd1);
        @(negedge clk);
        check("lat_send_next_edge", 32'(tx_send), 32'd1);
        check("lat_tx_data", 32'(tx_data), 32'hA9);
        wait_idle(100);
        check("single_count_zero", 32'(count), 32'd0);

        // Three-byte burst on consecutive cycles
        push_byte(8'h99, 1'b1);
        push_byte(8'hB1, 1'b1);
        push_byte(8'hEA, 1'b1);
        check("burst_peak_count", 32'(count), 32'd3);
        wait_idle(200);
        check("burst_count_zero", 32'(count), 32'd0);

        // Fill with the line held busy by a foreign source
        foreign_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b1);
        check("fill_full",     32'(full),     32'd1);
        check("fill_count",    32'(count),    32'd16);
        check("fill_no_ovf",   32'(overflow), 32'd0);
        check("fill_no_send",  32'(tx_send),  32'd0);
        push_byte(8'h10, 1'b0);
        check("drop_overflow", 32'(overflow), 32'd1);
        check("drop_count",    32'(count),    32'd16);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_overflow",  32'(overflow), 32'd0);

        // Release the line; push into the pop cycle is still dropped
        foreign_busy = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (uart_busy && tx_send) seen = 1'b1;
            end
            check("pop_cycle_reached", 32'(seen), 32'd1);
        end
        push_byte(8'h55, 1'b0);
        check("popdrop_count",    32'(count),    32'd15);
        check("popdrop_overflow", 32'(overflow), 32'd1);
        check("popdrop_full",     32'(full),     32'd0);
        wait_idle(600);
        check("fill_drain_count", 32'(count), 32'd0);

        // Reset while parked in LOAD with bytes queued
        uart_en = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i), 1'b0);
        check("park_send",  32'(tx_send), 32'd1);
        check("park_count", 32'(count),   32'd5);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_send",  32'(tx_send), 32'd0);
        check("midrst_count", 32'(count),   32'd0);
        check("midrst_empty", 32'(empty),   32'd1);
        reset   = 1'b1;
        uart_en = 1'b1;
        @(negedge clk);
        push_byte(8'h3C, 1'b1);
        wait_idle(100);
        check("post_rst_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
